// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: FSM encoding, channel count, dwell counter width.
package mux_scan_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam int SEL_W = 3;
  localparam int NCH   = 2 ** SEL_W;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Sample delivery channel of the mux scan sequencer: {channel, data} with valid/ready flow control.
interface mux_scan_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int SWIDTH = 3
) ();

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SWIDTH-1:0] out_ch;

  modport master (output out_valid, output out_data, output out_ch, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ch, output out_ready);

endinterface

// File: rtl/mux_next_ch_find.sv
// Priority search for the next enabled channel: lowest set mask bit strictly above cur,
// or the lowest set bit overall when from_start is high.
module mux_next_ch_find
  import mux_scan_pkg::*;
#(
  parameter int SWIDTH = SEL_W
) (
  input  logic [(2**SWIDTH)-1:0] mask,
  input  logic [SWIDTH-1:0]      cur,
  input  logic                   from_start,
  output logic                   found,
  output logic [SWIDTH-1:0]      next
);

  localparam int NCH_L = 2 ** SWIDTH;

  logic hit_s;

  // Scan from the top down so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    next  = {SWIDTH{1'b0}};
    hit_s = 1'b0;
    for (int i = NCH_L - 1; i >= 0; i--) begin
      hit_s = mask[i] & (from_start | (i > int'(cur)));
      found = found | hit_s;
      next  = hit_s ? SWIDTH'(i) : next;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the 8:1 mux select over the enabled channels, waits DWELL edges per channel, captures
// the mux output and hands {channel, data} to a single downstream consumer.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SWIDTH = SEL_W,
  parameter int DWELL  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cont,
  input  logic [(2**SWIDTH)-1:0] ch_mask,
  output logic [SWIDTH-1:0]      sel,
  input  logic [WIDTH-1:0]       mux_o,
  output logic                   busy,
  output logic                   scan_done,
  mux_scan_ctrl_if.master        out_if
);

  localparam int NCH_L = 2 ** SWIDTH;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [NCH_L-1:0]  mask_r;
  logic [SWIDTH-1:0] sel_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [SWIDTH-1:0] out_ch_r;
  logic              busy_r;
  logic              scan_done_r;

  logic              pass_found_s;
  logic [SWIDTH-1:0] pass_next_s;
  logic              first_found_s;
  logic [SWIDTH-1:0] first_next_s;

  // Next channel within the current pass, above the channel just delivered.
  mux_next_ch_find #(.SWIDTH(SWIDTH)) u_find_pass (
    .mask       (mask_r),
    .cur        (sel_r),
    .from_start (1'b0),
    .found      (pass_found_s),
    .next       (pass_next_s)
  );

  // First channel of a fresh pass, taken from the live mask that is about to be latched.
  mux_next_ch_find #(.SWIDTH(SWIDTH)) u_find_first (
    .mask       (ch_mask),
    .cur        ({SWIDTH{1'b0}}),
    .from_start (1'b1),
    .found      (first_found_s),
    .next       (first_next_s)
  );

  // Scan FSM, dwell counter, mask latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      mask_r      <= {NCH_L{1'b0}};
      sel_r       <= {SWIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_ch_r    <= {SWIDTH{1'b0}};
      busy_r      <= 1'b0;
      scan_done_r <= 1'b0;
    end else begin
      scan_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && first_found_s) begin
            mask_r  <= ch_mask;
            sel_r   <= first_next_s;
            cnt_r   <= DWELL_LOAD;
            busy_r  <= 1'b1;
            state_r <= ST_SETTLE;
          end else if (start) begin
            scan_done_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            out_data_r  <= mux_o;
            out_ch_r    <= sel_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_if.out_ready) begin
            out_valid_r <= 1'b0;
            if (pass_found_s) begin
              sel_r   <= pass_next_s;
              cnt_r   <= DWELL_LOAD;
              state_r <= ST_SETTLE;
            end else if (cont && first_found_s) begin
              // Wrap: the new pass uses whatever mask is presented now.
              mask_r  <= ch_mask;
              sel_r   <= first_next_s;
              cnt_r   <= DWELL_LOAD;
              state_r <= ST_SETTLE;
            end else begin
              mask_r      <= cont ? ch_mask : mask_r;
              scan_done_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_IDLE;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel              = sel_r;
  assign busy             = busy_r;
  assign scan_done        = scan_done_r;
  assign out_if.out_valid = out_valid_r;
  assign out_if.out_data  = out_data_r;
  assign out_if.out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed scoreboard bench for mux_scan_ctrl with an i_k = k+1 mux model and DWELL = 2.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             cont;
  logic [NCH-1:0]   ch_mask;
  logic [2:0]       sel;
  logic [3:0]       mux_o;
  logic             busy;
  logic             scan_done;

  mux_scan_ctrl_if #(.WIDTH(4), .SWIDTH(3)) bus ();

  mux_scan_ctrl #(.WIDTH(4), .SWIDTH(3), .DWELL(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont      (cont),
    .ch_mask   (ch_mask),
    .sel       (sel),
    .mux_o     (mux_o),
    .busy      (busy),
    .scan_done (scan_done),
    .out_if    (bus)
  );

  assign mux_o = 4'(sel) + 4'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [6:0] sb[$];
  logic       track   = 1'b0;
  logic       chk_gap = 1'b0;
  logic [7:0] visited = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops and compares every accepted sample, tracks visited selects and inter-sample gap.
  initial begin
    int         cyc;
    int         last;
    logic       have_last;
    logic [6:0] exp;
    cyc       = 0;
    last      = 0;
    have_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!track) visited = 8'd0;
      else if (busy) visited[sel] = 1'b1;
      if (!chk_gap) have_last = 1'b0;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("sample", 32'({bus.out_ch, bus.out_data}), 32'(exp));
        end
        if (chk_gap && have_last) check("gap", 32'(cyc - last), 32'd3);
        last      = cyc;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    start         = 1'b0;
    cont          = 1'b0;
    ch_mask       = 8'h00;
    bus.out_ready = 1'b0;
    #23;
    check("reset_state", 32'({sel, bus.out_valid, bus.out_data, bus.out_ch, busy, scan_done}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: full mask, single pass, latency and throughput
    ch_mask = 8'hFF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back({3'(k), 4'(k + 1)});
    chk_gap = 1'b1;
    pulse_start();
    check("t1_busy_after_start", 32'({busy, bus.out_valid}), 32'b10);
    tick();
    check("t1_no_valid_e1", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid_e2", 32'({bus.out_valid, bus.out_ch, bus.out_data}), 32'({1'b1, 3'd0, 4'd1}));
    drain("t1_drain", 60);
    check("t1_done_busy", 32'({scan_done, busy}), 32'b10);
    tick();
    check("t1_done_pulse_end", 32'({scan_done, busy, bus.out_valid}), 32'd0);
    chk_gap = 1'b0;
    tick();

    // 2: sparse mask, select visits only enabled channels
    ch_mask = 8'b1010_0100;
    track   = 1'b1;
    sb.push_back({3'd2, 4'd3});
    sb.push_back({3'd5, 4'd6});
    sb.push_back({3'd7, 4'd8});
    pulse_start();
    drain("t2_drain", 40);
    check("t2_done", 32'(scan_done), 32'd1);
    tick();
    check("t2_visited", 32'(visited), 32'hA4);
    track = 1'b0;
    tick();

    // 3: back-pressure on channel 3
    ch_mask = 8'hFF;
    for (int k = 0; k < 8; k++) sb.push_back({3'(k), 4'(k + 1)});
    pulse_start();
    n = 0;
    while (!(busy && sel == 3'd3 && !bus.out_valid) && n < 40) begin tick(); n++; end
    check("t3_reach_ch3", 32'(sel), 32'd3);
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 10) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_stable", 32'({bus.out_valid, bus.out_data, bus.out_ch, sel}),
            32'({1'b1, 4'd4, 3'd3, 3'd3}));
      tick();
    end
    bus.out_ready = 1'b1;
    drain("t3_drain", 40);
    tick();

    // 4: continuous over channels 0 and 7, then cont dropped during channel 0
    ch_mask = 8'h81;
    cont    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back({3'd0, 4'd1});
      sb.push_back({3'd7, 4'd8});
    end
    pulse_start();
    drain("t4_drain_cont", 40);
    check("t4_wrapped", 32'({scan_done, busy, sel}), 32'({1'b0, 1'b1, 3'd0}));
    cont = 1'b0;
    sb.push_back({3'd0, 4'd1});
    sb.push_back({3'd7, 4'd8});
    drain("t4_drain_last", 20);
    check("t4_done", 32'({scan_done, busy}), 32'b10);
    tick();

    // 5: empty mask
    ch_mask = 8'h00;
    pulse_start();
    check("t5_done_pulse", 32'({scan_done, busy, bus.out_valid}), 32'b100);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n += int'(scan_done) + int'(bus.out_valid) + int'(busy);
    end
    check("t5_quiet", 32'(n), 32'd0);

    // 6: asynchronous reset while holding channel 5
    ch_mask = 8'hFF;
    for (int k = 0; k < 5; k++) sb.push_back({3'(k), 4'(k + 1)});
    pulse_start();
    n = 0;
    while (!(busy && sel == 3'd5 && !bus.out_valid) && n < 40) begin tick(); n++; end
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 10) begin tick(); n++; end
    check("t6_hold_ch5", 32'({bus.out_valid, bus.out_ch}), 32'({1'b1, 3'd5}));
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 32'({sel, bus.out_valid, bus.out_data, bus.out_ch, busy, scan_done}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    ch_mask = 8'b0011_0000;
    sb.push_back({3'd4, 4'd5});
    sb.push_back({3'd5, 4'd6});
    pulse_start();
    check("t6_restart_sel", 32'({busy, sel}), 32'({1'b1, 3'd4}));
    drain("t6_drain", 30);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
